avalon_csr_bank: RTL and testbench

Parametrised Avalon-MM slave control/status register bank, the next generation of the fixed 8-register SRAM-controller bus wrapper. It adds:
- configurable count and width of RW config and RO status registers
- byte enables
- registered reads with readdatavalid
- a self-clearing command register
- a masked, write-1-to-clear interrupt block

It sits between the Nios/Avalon interconnect and a user datapath such as the SRAM test controller.

---
 rtl/csr_bank_pkg.sv | 17 +
 rtl/csr_irq_ctrl.sv | 37 +++
 rtl/avalon_csr_bank.sv | 103 ++++++++++
 tb/tb_avalon_csr_bank.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/csr_bank_pkg.sv
// csr_bank_pkg: shared address-map helpers and byte-mask expansion for the CSR bank
package csr_bank_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int NUM_BYTES = DEF_DATA_W / 8;
  function automatic int irq_status_addr(input int n_rw, input int n_ro);
    return n_rw + n_ro;
  endfunction
  function automatic int irq_mask_addr(input int n_rw, input int n_ro);
    return irq_status_addr(n_rw, n_ro) + 1;
  endfunction
  function automatic int cmd_addr(input int n_rw, input int n_ro);
    return irq_status_addr(n_rw, n_ro) + 2;
  endfunction
  function automatic logic [7:0] byte_fill(input logic en);
    return {8{en}};
  endfunction
endpackage

// File: rtl/csr_irq_ctrl.sv
// csr_irq_ctrl: sticky write-1-to-clear pending bits, mask register and registered irq
module csr_irq_ctrl #(
  parameter int N_IRQ = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_evt_i,
  input  logic [N_IRQ-1:0] w1c_i,
  input  logic             mask_we_i,
  input  logic [N_IRQ-1:0] mask_i,
  output logic [N_IRQ-1:0] pending_o,
  output logic [N_IRQ-1:0] mask_o,
  output logic             irq_o
);
  logic [N_IRQ-1:0] pending_q, pending_d, mask_q, mask_d;
  logic             irq_q, irq_d;
  // new events are OR-ed in after the clear so a same-cycle set wins
  always_comb begin
    pending_d = (pending_q & ~w1c_i) | irq_evt_i;
    mask_d    = mask_we_i ? mask_i : mask_q;
    irq_d     = |(pending_q & mask_q);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      mask_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      irq_q     <= irq_d;
    end
  end
  assign pending_o = pending_q;
  assign mask_o    = mask_q;
  assign irq_o     = irq_q;
endmodule

// File: rtl/avalon_csr_bank.sv
// avalon_csr_bank: Avalon-MM slave with RW config, shadowed RO status, W1C irq block
// and a self-clearing command strobe register; reads return one cycle after the strobe.
module avalon_csr_bank
  import csr_bank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = 4,
  parameter int N_RW   = 6,
  parameter int N_RO   = 4,
  parameter int N_IRQ  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   chipselect,
  input  logic [ADDR_W-1:0]      address,
  input  logic                   write,
  input  logic [DATA_W-1:0]      writedata,
  input  logic [DATA_W/8-1:0]    byteenable,
  input  logic                   read,
  output logic [DATA_W-1:0]      readdata,
  output logic                   readdatavalid,
  output logic [N_RW*DATA_W-1:0] cfg_out,
  input  logic [N_RO*DATA_W-1:0] sts_in,
  input  logic [N_IRQ-1:0]       irq_evt,
  output logic [DATA_W-1:0]      cmd_pulse,
  output logic                   irq
);
  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] A_STS = ADDR_W'(irq_status_addr(N_RW, N_RO));
  localparam logic [ADDR_W-1:0] A_MSK = ADDR_W'(irq_mask_addr(N_RW, N_RO));
  localparam logic [ADDR_W-1:0] A_CMD = ADDR_W'(cmd_addr(N_RW, N_RO));
  if (DATA_W % 8 != 0 || N_IRQ > DATA_W || N_RW + N_RO + 3 > 2**ADDR_W) begin : g_bad_params
    $error("avalon_csr_bank: illegal parameter combination");
  end
  logic                   wr, rd;
  logic [DATA_W-1:0]      wmask, wd_m, rd_mux;
  logic [DATA_W-1:0]      cfg_q [N_RW];
  logic [DATA_W-1:0]      cfg_d [N_RW];
  logic [N_RO*DATA_W-1:0] sts_q;
  logic [DATA_W-1:0]      rdata_q, rdata_d, cmd_q, cmd_d;
  logic                   rvalid_q;
  logic [N_IRQ-1:0]       pending, mask, w1c, mask_wd;
  logic                   mask_we;
  // a write in the same cycle as a read suppresses the read entirely
  assign wr = chipselect & write;
  assign rd = chipselect & read & ~write;
  for (genvar b = 0; b < NB; b++) begin : g_be
    assign wmask[b*8 +: 8] = byte_fill(byteenable[b]);
  end
  assign wd_m = writedata & wmask;
  always_comb begin
    for (int k = 0; k < N_RW; k++)
      cfg_d[k] = (wr && address == ADDR_W'(k)) ? (cfg_q[k] & ~wmask) | wd_m : cfg_q[k];
  end
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < N_RW; k++)
      if (address == ADDR_W'(k)) rd_mux = cfg_q[k];
    for (int k = 0; k < N_RO; k++)
      if (address == ADDR_W'(N_RW + k)) rd_mux = sts_q[k*DATA_W +: DATA_W];
    if (address == A_STS) rd_mux = DATA_W'(pending);
    if (address == A_MSK) rd_mux = DATA_W'(mask);
  end
  always_comb begin
    rdata_d = rd ? rd_mux : rdata_q;
    cmd_d   = (wr && address == A_CMD) ? wd_m : '0;
    w1c     = (wr && address == A_STS) ? wd_m[N_IRQ-1:0] : '0;
    mask_we = wr && address == A_MSK;
    mask_wd = (mask & ~wmask[N_IRQ-1:0]) | wd_m[N_IRQ-1:0];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_RW; k++) cfg_q[k] <= '0;
      sts_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      cmd_q    <= '0;
    end else begin
      for (int k = 0; k < N_RW; k++) cfg_q[k] <= cfg_d[k];
      sts_q    <= sts_in;
      rdata_q  <= rdata_d;
      rvalid_q <= rd;
      cmd_q    <= cmd_d;
    end
  end
  csr_irq_ctrl #(.N_IRQ(N_IRQ)) u_irq (
    .clk       (clk),
    .reset     (reset),
    .irq_evt_i (irq_evt),
    .w1c_i     (w1c),
    .mask_we_i (mask_we),
    .mask_i    (mask_wd),
    .pending_o (pending),
    .mask_o    (mask),
    .irq_o     (irq)
  );
  for (genvar k = 0; k < N_RW; k++) begin : g_cfg
    assign cfg_out[k*DATA_W +: DATA_W] = cfg_q[k];
  end
  assign readdata      = rdata_q;
  assign readdatavalid = rvalid_q;
  assign cmd_pulse     = cmd_q;
endmodule

// File: tb/tb_avalon_csr_bank.sv
// tb_avalon_csr_bank: table-driven register checks with a read scoreboard,
// plus hand-written command, interrupt, read/write collision and reset sequences.
module tb_avalon_csr_bank;
  localparam int DW = 32, AW = 4, NRW = 6, NRO = 4, NIRQ = 4, NB = DW / 8;
  logic              clk = 1'b0, reset = 1'b1;
  logic              chipselect = 1'b0, write = 1'b0, read = 1'b0;
  logic [AW-1:0]     address = '0;
  logic [DW-1:0]     writedata = '0;
  logic [NB-1:0]     byteenable = '0;
  logic [DW-1:0]     readdata, cmd_pulse;
  logic              readdatavalid, irq;
  logic [NRW*DW-1:0] cfg_out;
  logic [NRO*DW-1:0] sts_in = '0;
  logic [NIRQ-1:0]   irq_evt = '0;
  typedef struct {
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [NB-1:0] be;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t          vecs [14];
  logic [DW-1:0] sb [$];
  int            n_tests = 0, n_fail = 0;
  avalon_csr_bank #(.DATA_W(DW), .ADDR_W(AW), .N_RW(NRW), .N_RO(NRO), .N_IRQ(NIRQ)) dut (
    .clk           (clk),
    .reset         (reset),
    .chipselect    (chipselect),
    .address       (address),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .read          (read),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .cfg_out       (cfg_out),
    .sts_in        (sts_in),
    .irq_evt       (irq_evt),
    .cmd_pulse     (cmd_pulse),
    .irq           (irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask
  // every cycle: readdatavalid must match the scoreboard, and data must match its head
  task automatic monitor();
    chk("readdatavalid", DW'(readdatavalid), DW'(sb.size() != 0));
    if (readdatavalid && sb.size() != 0) chk("readdata", readdata, sb.pop_front());
    else if (sb.size() != 0) void'(sb.pop_front());
  endtask
  task automatic drive(input logic cs, input logic wr, input logic rd, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [NB-1:0] be, input logic [DW-1:0] exp);
    chipselect = cs; write = wr; read = rd; address = a; writedata = wd; byteenable = be;
    if (cs && rd && !wr) sb.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    monitor();
  endtask
  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask
  task automatic wr_reg(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    drive(1'b1, 1'b1, 1'b0, a, d, be, '0);
  endtask
  task automatic rd_reg(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    drive(1'b1, 1'b0, 1'b1, a, '0, '0, exp);
  endtask
  initial begin
    vecs[0]  = '{1'b1, 1'b0, 4'd2,  32'hAABBCCDD, 4'b0101, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 4'd2,  32'h0,        4'h0,    32'h00BB00DD};
    vecs[2]  = '{1'b1, 1'b0, 4'd7,  32'hFFFFFFFF, 4'hF,    32'h0};
    vecs[3]  = '{1'b0, 1'b1, 4'd7,  32'h0,        4'h0,    32'h12345678};
    vecs[4]  = '{1'b1, 1'b0, 4'd0,  32'h12345678, 4'hF,    32'h0};
    vecs[5]  = '{1'b0, 1'b1, 4'd0,  32'h0,        4'h0,    32'h12345678};
    vecs[6]  = '{1'b1, 1'b0, 4'd5,  32'hDEADBEEF, 4'b1000, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 4'd5,  32'h0,        4'h0,    32'hDE000000};
    vecs[8]  = '{1'b1, 1'b0, 4'd14, 32'hFFFFFFFF, 4'hF,    32'h0};
    vecs[9]  = '{1'b0, 1'b1, 4'd14, 32'h0,        4'h0,    32'h0};
    vecs[10] = '{1'b0, 1'b1, 4'd6,  32'h0,        4'h0,    32'hCAFEF00D};
    vecs[11] = '{1'b0, 1'b1, 4'd9,  32'h0,        4'h0,    32'h00000009};
    vecs[12] = '{1'b1, 1'b0, 4'd0,  32'h000000EE, 4'b0001, 32'h0};
    vecs[13] = '{1'b0, 1'b1, 4'd0,  32'h0,        4'h0,    32'h123456EE};
    repeat (2) @(negedge clk);
    chk("reset_readdata", readdata, '0);
    chk("reset_rdv", DW'(readdatavalid), '0);
    chk("reset_irq", DW'(irq), '0);
    chk("reset_cmd", cmd_pulse, '0);
    chk("reset_cfg0", cfg_out[31:0], '0);
    reset = 1'b0;
    idle();
    for (int a = 0; a < 16; a++) rd_reg(AW'(a), '0);
    chk("idle_irq", DW'(irq), '0);
    chk("idle_cmd", cmd_pulse, '0);
    sts_in = {32'h00000009, 32'h5555AAAA, 32'h12345678, 32'hCAFEF00D};
    idle();
    for (int i = 0; i < 14; i++)
      drive(1'b1, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wd, vecs[i].be, vecs[i].exp);
    chk("cfg_out2", cfg_out[95:64], 32'h00BB00DD);
    chk("cfg_out5", cfg_out[191:160], 32'hDE000000);
    chk("cfg_out0", cfg_out[31:0], 32'h123456EE);
    idle();
    chk("rdata_hold", readdata, 32'h123456EE);
    wr_reg(4'd12, 32'h5, 4'hF);
    chk("cmd_pulse", cmd_pulse, 32'h5);
    idle();
    chk("cmd_clear", cmd_pulse, '0);
    wr_reg(4'd12, 32'h3, 4'hF);
    chk("cmd_b2b_a", cmd_pulse, 32'h3);
    wr_reg(4'd12, 32'hABCDF0F0, 4'b0011);
    chk("cmd_b2b_b", cmd_pulse, 32'h0000F0F0);
    idle();
    chk("cmd_clear2", cmd_pulse, '0);
    rd_reg(4'd12, '0);
    drive(1'b1, 1'b1, 1'b1, 4'd0, 32'h1, 4'hF, '0);
    rd_reg(4'd0, 32'h1);
    wr_reg(4'd11, 32'h4, 4'hF);
    irq_evt = 4'b0100;
    idle();
    irq_evt = '0;
    chk("irq_lag", DW'(irq), '0);
    idle();
    chk("irq_rise", DW'(irq), 32'h1);
    rd_reg(4'd10, 32'h4);
    irq_evt = 4'b0100;
    wr_reg(4'd10, 32'h4, 4'hF);
    irq_evt = '0;
    rd_reg(4'd10, 32'h4);
    chk("irq_set_wins", DW'(irq), 32'h1);
    wr_reg(4'd10, 32'h4, 4'hF);
    chk("irq_fall_lag", DW'(irq), 32'h1);
    idle();
    chk("irq_fall", DW'(irq), '0);
    rd_reg(4'd10, '0);
    irq_evt = 4'b0001;
    idle();
    irq_evt = '0;
    idle();
    idle();
    chk("irq_masked", DW'(irq), '0);
    rd_reg(4'd10, 32'h1);
    rd_reg(4'd11, 32'h4);
    wr_reg(4'd10, 32'h1, 4'b0010);
    rd_reg(4'd10, 32'h1);
    wr_reg(4'd10, 32'h1, 4'hF);
    rd_reg(4'd10, '0);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 4'd0;
    #2 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rdv_reset_abort", DW'(readdatavalid), '0);
    chipselect = 1'b0; read = 1'b0; reset = 1'b0;
    idle();
    chk("cfg_after_reset", cfg_out[31:0], '0);
    rd_reg(4'd11, '0);
    rd_reg(4'd2, '0);
    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
